// File: rtl/beep_pattern_ctrl.sv
// Multi-key buzzer controller: key 0 toggles continuous sound, key k plays k timed beeps.
// Optional square-wave tone for passive buzzers; all outputs registered.
module beep_pattern_ctrl #(
   parameter int   NUM_KEYS     = 4,
   parameter int   BEEP_ON_CYC  = 5_000_000,
   parameter int   BEEP_OFF_CYC = 5_000_000,
   parameter int   TONE_HALF    = 0,
   parameter logic ACTIVE_LVL   = 1'b1,
   parameter int   CNT_W        = 24
) (
   input  logic                sys_clk,
   input  logic                sys_rst,
   input  logic [NUM_KEYS-1:0] key_value,
   input  logic                key_flag,
   output logic                beep,
   output logic                busy
);

   // state     | meaning
   // IDLE      | silent, waiting for a key
   // CONT      | sounding until key 0 is pressed again
   // BURST_ON  | sounding one beep of a burst
   // BURST_OFF | silent gap between burst beeps
   typedef enum logic [1:0] {IDLE, CONT, BURST_ON, BURST_OFF} state_t;

   localparam int REM_W = $clog2(NUM_KEYS);
   localparam logic [CNT_W-1:0] ON_LAST   = CNT_W'(BEEP_ON_CYC - 1);
   localparam logic [CNT_W-1:0] OFF_LAST  = CNT_W'(BEEP_OFF_CYC - 1);
   localparam logic [CNT_W-1:0] TONE_LAST = CNT_W'((TONE_HALF > 0) ? TONE_HALF - 1 : 0);

   state_t           state, state_n;
   logic [REM_W-1:0] rem, rem_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic [CNT_W-1:0] tcnt, tcnt_n;
   logic             tone_lvl, tone_lvl_n;
   logic             beep_n;
   logic             key_hit;
   logic [REM_W-1:0] key_sel;
   logic             sound_n;
   logic             enter;

   always_comb begin
      key_sel = '0;
      for (int i = NUM_KEYS - 1; i >= 0; i--) begin
         if (!key_value[i]) key_sel = REM_W'(i);
      end
      key_hit = key_flag && (key_value != '1);
   end

   always_comb begin
      state_n = state;
      rem_n   = rem;
      cnt_n   = cnt;
      case (state)
         BURST_ON: begin
            if (cnt == ON_LAST) begin
               cnt_n = '0;
               if (rem != '0) rem_n = rem - REM_W'(1);
               state_n = (rem <= REM_W'(1)) ? IDLE : BURST_OFF;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         BURST_OFF: begin
            if (cnt == OFF_LAST) begin
               cnt_n   = '0;
               state_n = BURST_ON;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         default: ;
      endcase
      // A key event overrides any terminal-count transition in the same cycle
      if (key_hit) begin
         cnt_n = '0;
         if (key_sel == '0) begin
            rem_n   = '0;
            state_n = (state == CONT) ? IDLE : CONT;
         end else begin
            rem_n   = key_sel;
            state_n = BURST_ON;
         end
      end
   end

   always_comb begin
      sound_n    = (state_n == CONT) || (state_n == BURST_ON);
      enter      = sound_n && ((state_n != state) || key_hit);
      tcnt_n     = '0;
      tone_lvl_n = ACTIVE_LVL;
      if (sound_n && !enter) begin
         if (tcnt == TONE_LAST) begin
            tone_lvl_n = ~tone_lvl;
         end else begin
            tcnt_n     = tcnt + 1'b1;
            tone_lvl_n = tone_lvl;
         end
      end
      if (!sound_n)            beep_n = ~ACTIVE_LVL;
      else if (TONE_HALF == 0) beep_n = ACTIVE_LVL;
      else                     beep_n = tone_lvl_n;
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state    <= IDLE;
         rem      <= '0;
         cnt      <= '0;
         tcnt     <= '0;
         tone_lvl <= ACTIVE_LVL;
         beep     <= ~ACTIVE_LVL;
         busy     <= 1'b0;
      end else begin
         state    <= state_n;
         rem      <= rem_n;
         cnt      <= cnt_n;
         tcnt     <= tcnt_n;
         tone_lvl <= tone_lvl_n;
         beep     <= beep_n;
         busy     <= (state_n != IDLE);
      end
   end

endmodule

// File: tb/tb_beep_pattern_ctrl.sv
// Bench for beep_pattern_ctrl: an active-buzzer and a tone-mode instance share stimulus,
// both checked every cycle against an elapsed-time model of the beep schedule.
module tb_beep_pattern_ctrl;

   localparam int NK  = 4;
   localparam int ON  = 5;
   localparam int OFF = 3;
   localparam int TH  = 2;

   logic          sys_clk = 1'b0;
   logic          sys_rst = 1'b1;
   logic          key_flag = 1'b0;
   logic [NK-1:0] key_value = '1;
   logic          beep_a, busy_a, beep_t, busy_t;

   always #5 sys_clk = ~sys_clk;

   beep_pattern_ctrl #(.NUM_KEYS(NK), .BEEP_ON_CYC(ON), .BEEP_OFF_CYC(OFF), .TONE_HALF(0),
                       .ACTIVE_LVL(1'b1), .CNT_W(8)) dut_a (
      .sys_clk(sys_clk), .sys_rst(sys_rst), .key_value(key_value), .key_flag(key_flag),
      .beep(beep_a), .busy(busy_a));

   beep_pattern_ctrl #(.NUM_KEYS(NK), .BEEP_ON_CYC(ON), .BEEP_OFF_CYC(OFF), .TONE_HALF(TH),
                       .ACTIVE_LVL(1'b1), .CNT_W(8)) dut_t (
      .sys_clk(sys_clk), .sys_rst(sys_rst), .key_value(key_value), .key_flag(key_flag),
      .beep(beep_t), .busy(busy_t));

   int n_cmp = 0;
   int n_mis = 0;

   // mode: 0 silent, 1 continuous, 2 burst of m_k beeps; m_e = cycles since mode entry
   int m_mode = 0;
   int m_k    = 0;
   int m_e    = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $display("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
         $error("%s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_edge(input logic rst, input logic flag, input logic [NK-1:0] kv);
      int sel;
      if (rst) begin
         m_mode = 0;
         m_e    = 0;
      end else if (flag && kv != '1) begin
         sel = -1;
         for (int i = NK - 1; i >= 0; i--) if (!kv[i]) sel = i;
         m_e = 0;
         if (sel == 0) m_mode = (m_mode == 1) ? 0 : 1;
         else begin
            m_mode = 2;
            m_k    = sel;
         end
      end else begin
         m_e++;
         if (m_mode == 2 && m_e >= m_k * ON + (m_k - 1) * OFF) m_mode = 0;
      end
   endtask

   function automatic logic exp_sound();
      return (m_mode == 1) || (m_mode == 2 && (m_e % (ON + OFF)) < ON);
   endfunction

   function automatic logic exp_tone();
      int s;
      s = (m_mode == 1) ? m_e : m_e % (ON + OFF);
      return exp_sound() && ((s / TH) % 2 == 0);
   endfunction

   task automatic cycle(input logic rst, input logic flag, input logic [NK-1:0] kv);
      sys_rst   = rst;
      key_flag  = flag;
      key_value = kv;
      @(posedge sys_clk);
      model_edge(rst, flag, kv);
      @(negedge sys_clk);
      chk("beep", beep_a, exp_sound());
      chk("busy", busy_a, m_mode != 0);
      chk("beep_tone", beep_t, exp_tone());
      chk("busy_tone", busy_t, m_mode != 0);
      sys_rst   = 1'b0;
      key_flag  = 1'b0;
      key_value = '1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, '1);
   endtask

   initial begin
      int          busy_cnt;
      int          beep_cnt;
      logic [5:0]  pat;
      logic        r, f;
      logic [NK-1:0] kv;

      // reset held two cycles, then quiet
      cycle(1'b1, 1'b0, '1);
      chk("reset_beep", beep_a, 1'b0);
      cycle(1'b1, 1'b0, '1);
      idle(3);

      // key 2 burst: 13 busy cycles, 10 sounding
      cycle(1'b0, 1'b1, 4'b1011);
      busy_cnt = int'(busy_a);
      beep_cnt = int'(beep_a);
      for (int i = 0; i < 19; i++) begin
         cycle(1'b0, 1'b0, '1);
         busy_cnt += int'(busy_a);
         beep_cnt += int'(beep_a);
      end
      chk("key2_busy_len", busy_cnt, 13);
      chk("key2_beep_len", beep_cnt, 10);

      // key 0 toggle
      cycle(1'b0, 1'b1, 4'b1110);
      idle(20);
      cycle(1'b0, 1'b1, 4'b1110);
      chk("cont_off", busy_a, 1'b0);
      idle(3);

      // key 3 burst aborted in its second gap by key 1
      cycle(1'b0, 1'b1, 4'b0111);
      idle(14);
      chk("abort_in_gap", beep_a, 1'b0);
      cycle(1'b0, 1'b1, 4'b1101);
      beep_cnt = int'(beep_a);
      for (int i = 0; i < 9; i++) begin
         cycle(1'b0, 1'b0, '1);
         beep_cnt += int'(beep_a);
      end
      chk("abort_single_beep", beep_cnt, 5);

      // simultaneous keys 1 and 3 select key 1
      cycle(1'b0, 1'b1, 4'b0101);
      idle(10);

      // release event ignored
      cycle(1'b0, 1'b1, 4'b1111);
      chk("release_ignored", busy_a, 1'b0);
      idle(2);

      // key 0 on the terminal cycle of a key-1 burst
      cycle(1'b0, 1'b1, 4'b1101);
      idle(4);
      cycle(1'b0, 1'b1, 4'b1110);
      chk("collision_cont", beep_a, 1'b1);
      idle(5);
      cycle(1'b0, 1'b1, 4'b1110);
      idle(2);

      // tone pattern for a single beep
      cycle(1'b0, 1'b1, 4'b1101);
      pat = {5'b0, beep_t};
      for (int i = 0; i < 5; i++) begin
         cycle(1'b0, 1'b0, '1);
         pat = {pat[4:0], beep_t};
      end
      chk("tone_pattern", pat, 6'b110010);
      idle(2);

      // reset during continuous sound
      cycle(1'b0, 1'b1, 4'b1110);
      idle(3);
      cycle(1'b1, 1'b0, '1);
      chk("mid_reset_beep", beep_a, 1'b0);
      idle(2);

      // randomized key traffic
      for (int i = 0; i < 3000; i++) begin
         r  = ($urandom_range(0, 299) == 0);
         f  = ($urandom_range(0, 7) == 0);
         kv = NK'($urandom);
         cycle(r, f, kv);
      end
      idle(40);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
